// File: rtl/pdes_pkg.sv
// Shared types and message helpers for the PHOLD event scheduler.
// Message layout: [time | lp | cancel] from bit 0 upward.
package pdes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INIT   = 2'd1,
        ST_RUN    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam int DEF_TIME_WID = 16;
    localparam int DEF_NB_LPID  = 6;
    localparam int DEF_MSG_WID  = 32;

    function automatic int msg_lp_off(input int time_wid);
        return time_wid;
    endfunction

    function automatic int msg_cancel_off(input int time_wid, input int nb_lpid);
        return time_wid + nb_lpid;
    endfunction

    // Fields arrive zero-extended to 32 bits so the check is width-independent.
    function automatic logic is_null_msg(input logic cancel, input logic [31:0] lp,
                                         input logic [31:0] t);
        return cancel && (lp == 32'd0) && (t == 32'd0);
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer;
// the pointer moves just past the winner only when the grant is used (adv).
module rr_arb #(
    parameter int N  = 8,
    parameter int NB = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          adv,
    output logic [N-1:0]  gnt,
    output logic [NB-1:0] gnt_idx
);

    localparam logic [NB:0] NP = (NB+1)'(N);

    logic [NB-1:0] ptr_r;
    logic [N-1:0]  gnt_s;
    logic [NB-1:0] idx_s;
    logic [NB-1:0] k_s;
    logic [NB:0]   sum_s;
    logic [NB:0]   nxt_s;
    logic          found_s;
    logic          hit_s;

    // Rotating priority search beginning at ptr_r.
    always_comb begin
        gnt_s   = {N{1'b0}};
        idx_s   = {NB{1'b0}};
        found_s = 1'b0;
        hit_s   = 1'b0;
        sum_s   = {(NB+1){1'b0}};
        k_s     = {NB{1'b0}};
        for (int i = 0; i < N; i++) begin
            sum_s      = {1'b0, ptr_r} + (NB+1)'(i);
            k_s        = (sum_s >= NP) ? (sum_s[NB-1:0] - NP[NB-1:0]) : sum_s[NB-1:0];
            hit_s      = !found_s && req[k_s];
            found_s    = found_s | hit_s;
            gnt_s[k_s] = hit_s;
            idx_s      = hit_s ? k_s : idx_s;
        end
    end

    assign nxt_s   = {1'b0, idx_s} + {{NB{1'b0}}, 1'b1};
    assign gnt     = gnt_s;
    assign gnt_idx = idx_s;

    // Pointer advance on a used grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {NB{1'b0}};
        end else if (adv && found_s) begin
            ptr_r <= (nxt_s >= NP) ? {NB{1'b0}} : nxt_s[NB-1:0];
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/pdes_scheduler.sv
// PHOLD event scheduler: seeds one event per LP, moves new events from the cores into
// the external priority queue, dispatches the queue head, tracks GVT and termination.
module pdes_scheduler
    import pdes_pkg::*;
#(
    parameter int NUM_CORE  = 8,
    parameter int NB_COREID = 3,
    parameter int NUM_LP    = 64,
    parameter int NB_LPID   = DEF_NB_LPID,
    parameter int TIME_WID  = DEF_TIME_WID,
    parameter int MSG_WID   = DEF_MSG_WID
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [TIME_WID-1:0]          end_time,
    input  logic                         pause,
    input  logic [NUM_CORE-1:0]          core_out_vld,
    input  logic [NUM_CORE*MSG_WID-1:0]  core_out_msg,
    output logic [NUM_CORE-1:0]          core_out_ack,
    input  logic [NUM_CORE-1:0]          core_ready,
    output logic [NUM_CORE-1:0]          core_ev_vld,
    output logic [MSG_WID-1:0]           core_ev_msg,
    input  logic [NUM_CORE-1:0]          core_active,
    input  logic [NUM_CORE*TIME_WID-1:0] core_time,
    output logic                         q_enq,
    output logic                         q_deq,
    output logic [MSG_WID-1:0]           q_enq_data,
    input  logic [MSG_WID-1:0]           q_head,
    input  logic                         q_empty,
    input  logic                         q_full,
    output logic                         rng_next,
    output logic [TIME_WID-1:0]          gvt,
    output logic                         busy,
    output logic                         done,
    output logic                         quiesced,
    output logic                         full_stall
);

    localparam int OFF_LP  = msg_lp_off(TIME_WID);
    localparam int OFF_CAN = msg_cancel_off(TIME_WID, NB_LPID);
    localparam int NLEAF   = 1 << $clog2(NUM_CORE + 1);
    localparam logic [NB_LPID-1:0] LAST_LP = NB_LPID'(NUM_LP - 1);

    state_t                state_r, state_s;
    logic [NB_LPID-1:0]    cnt_r;
    logic [TIME_WID-1:0]   end_time_r;
    logic [TIME_WID-1:0]   gvt_r;
    logic                  quiesced_r;
    logic                  full_stall_r;
    logic                  done_r;
    logic                  busy_r;
    logic                  qseen_r;

    logic                  run_s, start_go_s, init_go_s, init_last_s;
    logic                  col_pend_s, col_go_s, col_null_s, dsp_go_s;
    logic                  qcond_s, term_gvt_s, term_q_s;
    logic [NUM_CORE-1:0]   col_gnt_s, dsp_gnt_s;
    logic [NB_COREID-1:0]  col_idx_s, dsp_idx_s;
    logic                  dsp_idx_unused_s;
    logic [MSG_WID-1:0]    col_msg_s, seed_msg_s;

    logic                  node_vld_s [2*NLEAF];
    logic [TIME_WID-1:0]   node_t_s   [2*NLEAF];
    logic                  take_s;

    rr_arb #(.N(NUM_CORE), .NB(NB_COREID)) u_col_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (core_out_vld),
        .adv     (col_go_s),
        .gnt     (col_gnt_s),
        .gnt_idx (col_idx_s)
    );

    rr_arb #(.N(NUM_CORE), .NB(NB_COREID)) u_dsp_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (core_ready),
        .adv     (dsp_go_s),
        .gnt     (dsp_gnt_s),
        .gnt_idx (dsp_idx_s)
    );

    // Dispatch only needs the one-hot grant.
    assign dsp_idx_unused_s = ^dsp_idx_s;

    assign run_s       = (state_r == ST_RUN);
    assign start_go_s  = (state_r == ST_IDLE) && start;
    assign init_go_s   = (state_r == ST_INIT) && !q_full;
    assign init_last_s = init_go_s && (cnt_r == LAST_LP);

    // Collection has priority; a blocked collection (q_full) still lets dispatch drain the queue.
    assign col_pend_s  = |core_out_vld;
    assign col_go_s    = run_s && col_pend_s && !q_full;
    assign dsp_go_s    = run_s && !col_go_s && !q_empty && (|core_ready) && !pause;

    assign col_msg_s   = core_out_msg[int'(col_idx_s)*MSG_WID +: MSG_WID];
    assign col_null_s  = is_null_msg(col_msg_s[OFF_CAN],
                                     32'(col_msg_s[OFF_LP +: NB_LPID]),
                                     32'(col_msg_s[TIME_WID-1:0]));

    assign qcond_s     = q_empty && !(|core_active) && !col_pend_s;
    assign term_gvt_s  = run_s && (gvt_r > end_time_r);
    assign term_q_s    = run_s && qcond_s && qseen_r;

    // Seed event for the current LP: time 0, not a cancel.
    always_comb begin
        seed_msg_s = {MSG_WID{1'b0}};
        seed_msg_s[OFF_LP +: NB_LPID] = cnt_r;
    end

    assign core_out_ack = col_go_s ? col_gnt_s : {NUM_CORE{1'b0}};
    assign core_ev_vld  = dsp_go_s ? dsp_gnt_s : {NUM_CORE{1'b0}};
    assign core_ev_msg  = q_head;
    assign q_enq        = init_go_s || (col_go_s && !col_null_s);
    assign q_deq        = dsp_go_s;
    assign q_enq_data   = init_go_s ? seed_msg_s : (col_go_s ? col_msg_s : {MSG_WID{1'b0}});
    assign rng_next     = init_go_s || dsp_go_s;

    assign gvt          = gvt_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign quiesced     = quiesced_r;
    assign full_stall   = full_stall_r;

    // GVT candidate: min-tree over active cores plus the queue head (heap-indexed, root at 1).
    always_comb begin
        node_vld_s = '{default: 1'b0};
        node_t_s   = '{default: {TIME_WID{1'b0}}};
        take_s     = 1'b0;
        for (int g = 0; g < NUM_CORE; g++) begin
            node_vld_s[NLEAF+g] = core_active[g];
            node_t_s[NLEAF+g]   = core_time[g*TIME_WID +: TIME_WID];
        end
        node_vld_s[NLEAF+NUM_CORE] = !q_empty;
        node_t_s[NLEAF+NUM_CORE]   = q_head[TIME_WID-1:0];
        for (int n = NLEAF - 1; n >= 1; n--) begin
            take_s = node_vld_s[2*n+1] &&
                     (!node_vld_s[2*n] || (node_t_s[2*n+1] < node_t_s[2*n]));
            node_vld_s[n] = node_vld_s[2*n] | node_vld_s[2*n+1];
            node_t_s[n]   = take_s ? node_t_s[2*n+1] : node_t_s[2*n];
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_INIT;
                else       state_s = ST_IDLE;
            end
            ST_INIT: begin
                if (init_last_s) state_s = ST_RUN;
                else             state_s = ST_INIT;
            end
            ST_RUN: begin
                if (term_gvt_s || term_q_s) state_s = ST_FINISH;
                else                        state_s = ST_RUN;
            end
            ST_FINISH: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // State register and state-derived status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_s == ST_FINISH);
        end
    end

    // Seed counter, latched end time and quiescence history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= {NB_LPID{1'b0}};
            end_time_r <= {TIME_WID{1'b0}};
            qseen_r    <= 1'b0;
        end else begin
            qseen_r <= run_s && qcond_s;
            if (start_go_s) begin
                cnt_r      <= {NB_LPID{1'b0}};
                end_time_r <= end_time;
            end else if (init_go_s) begin
                cnt_r      <= cnt_r + NB_LPID'(1);
                end_time_r <= end_time_r;
            end else begin
                cnt_r      <= cnt_r;
                end_time_r <= end_time_r;
            end
        end
    end

    // Sticky run flags, cleared by the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quiesced_r   <= 1'b0;
            full_stall_r <= 1'b0;
        end else if (start_go_s) begin
            quiesced_r   <= 1'b0;
            full_stall_r <= 1'b0;
        end else begin
            quiesced_r   <= quiesced_r | (term_q_s && !term_gvt_s);
            full_stall_r <= full_stall_r | (run_s && col_pend_s && q_full);
        end
    end

    // GVT register: follows the candidate in RUN, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gvt_r <= {TIME_WID{1'b0}};
        end else if (start_go_s) begin
            gvt_r <= {TIME_WID{1'b0}};
        end else if (run_s && node_vld_s[1]) begin
            gvt_r <= node_t_s[1];
        end else begin
            gvt_r <= gvt_r;
        end
    end

endmodule

// File: tb/tb_pdes_scheduler.sv
// Directed self-checking bench for pdes_scheduler (8 cores, 64 LPs).
module tb_pdes_scheduler;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [15:0]  end_time;
    logic         pause;
    logic [7:0]   core_out_vld;
    logic [255:0] core_out_msg;
    logic [7:0]   core_out_ack;
    logic [7:0]   core_ready;
    logic [7:0]   core_ev_vld;
    logic [31:0]  core_ev_msg;
    logic [7:0]   core_active;
    logic [127:0] core_time;
    logic         q_enq;
    logic         q_deq;
    logic [31:0]  q_enq_data;
    logic [31:0]  q_head;
    logic         q_empty;
    logic         q_full;
    logic         rng_next;
    logic [15:0]  gvt;
    logic         busy;
    logic         done;
    logic         quiesced;
    logic         full_stall;

    int checks   = 0;
    int failures = 0;
    int seen     = 0;

    pdes_scheduler #(
        .NUM_CORE(8), .NB_COREID(3), .NUM_LP(64), .NB_LPID(6), .TIME_WID(16), .MSG_WID(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .end_time(end_time), .pause(pause),
        .core_out_vld(core_out_vld), .core_out_msg(core_out_msg), .core_out_ack(core_out_ack),
        .core_ready(core_ready), .core_ev_vld(core_ev_vld), .core_ev_msg(core_ev_msg),
        .core_active(core_active), .core_time(core_time),
        .q_enq(q_enq), .q_deq(q_deq), .q_enq_data(q_enq_data), .q_head(q_head),
        .q_empty(q_empty), .q_full(q_full), .rng_next(rng_next), .gvt(gvt),
        .busy(busy), .done(done), .quiesced(quiesced), .full_stall(full_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic c, input logic [5:0] lp, input logic [15:0] t);
        mk = {9'd0, c, lp, t};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; end_time = 16'd0; pause = 1'b0;
        core_out_vld = 8'd0; core_out_msg = 256'd0; core_ready = 8'd0;
        core_active = 8'd0; core_time = 128'd0; q_head = 32'd0;
        q_empty = 1'b1; q_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",    64'(busy),         64'd0);
        chk("rst_done",    64'(done),         64'd0);
        chk("rst_gvt",     64'(gvt),          64'd0);
        chk("rst_enq",     64'(q_enq),        64'd0);
        chk("rst_deq",     64'(q_deq),        64'd0);
        chk("rst_ack",     64'(core_out_ack), 64'd0);
        chk("rst_evvld",   64'(core_ev_vld),  64'd0);
        chk("rst_rng",     64'(rng_next),     64'd0);
        chk("rst_quies",   64'(quiesced),     64'd0);
        chk("rst_fstall",  64'(full_stall),   64'd0);
        chk("rst_enqdata", 64'(q_enq_data),   64'd0);
        rst_n = 1'b1;
        tick();

        // T1: seeding, with one q_full stall
        start = 1'b1; end_time = 16'd100;
        tick();
        start = 1'b0;
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_gvt",  64'(gvt),  64'd0);
        q_empty = 1'b0; q_head = mk(1'b0, 6'd12, 16'd0);
        for (int c = 0; c < 80 && seen < 64; c++) begin
            q_full = (c == 10);
            #1;
            if (c == 10) begin
                chk("t1_stall_enq", 64'(q_enq),    64'd0);
                chk("t1_stall_rng", 64'(rng_next), 64'd0);
            end else begin
                chk("t1_seed_enq",  64'(q_enq),      64'd1);
                chk("t1_seed_data", 64'(q_enq_data), 64'(mk(1'b0, seen[5:0], 16'd0)));
                chk("t1_seed_rng",  64'(rng_next),   64'd1);
                if (q_enq === 1'b1) seen++;
            end
            @(posedge clk);
            #1;
        end
        q_full = 1'b0;
        chk("t1_seed_count", 64'(seen),     64'd64);
        chk("t1_run_busy",   64'(busy),     64'd1);
        chk("t1_run_enq",    64'(q_enq),    64'd0);
        chk("t1_run_rng",    64'(rng_next), 64'd0);

        // T2: simultaneous producers 2 and 5, dispatch held off by collection
        core_ready = 8'h01; core_out_vld = 8'h24;
        core_out_msg[2*32 +: 32] = mk(1'b0, 6'd7, 16'd20);
        core_out_msg[5*32 +: 32] = mk(1'b0, 6'd9, 16'd30);
        #1;
        chk("t2_ack2",   64'(core_out_ack), 64'h04);
        chk("t2_enq2",   64'(q_enq),        64'd1);
        chk("t2_data2",  64'(q_enq_data),   64'(mk(1'b0, 6'd7, 16'd20)));
        chk("t2_evvld2", 64'(core_ev_vld),  64'd0);
        chk("t2_deq2",   64'(q_deq),        64'd0);
        tick();
        core_out_vld = 8'h20;
        #1;
        chk("t2_ack5",   64'(core_out_ack), 64'h20);
        chk("t2_data5",  64'(q_enq_data),   64'(mk(1'b0, 6'd9, 16'd30)));
        chk("t2_evvld5", 64'(core_ev_vld),  64'd0);
        tick();
        core_out_vld = 8'h00;
        #1;
        chk("t2_dsp_vld", 64'(core_ev_vld), 64'h01);
        chk("t2_dsp_deq", 64'(q_deq),       64'd1);
        chk("t2_dsp_msg", 64'(core_ev_msg), 64'(mk(1'b0, 6'd12, 16'd0)));
        chk("t2_dsp_rng", 64'(rng_next),    64'd1);
        chk("t2_dsp_ack", 64'(core_out_ack), 64'd0);
        tick();
        core_ready = 8'h00;

        // T3: null message acked but not enqueued; cancel with nonzero lp is enqueued
        core_out_vld = 8'h10;
        core_out_msg[4*32 +: 32] = mk(1'b1, 6'd0, 16'd0);
        #1;
        chk("t3_null_ack", 64'(core_out_ack), 64'h10);
        chk("t3_null_enq", 64'(q_enq),        64'd0);
        tick();
        core_out_msg[4*32 +: 32] = mk(1'b1, 6'd3, 16'd0);
        #1;
        chk("t3_cancel_ack",  64'(core_out_ack), 64'h10);
        chk("t3_cancel_enq",  64'(q_enq),        64'd1);
        chk("t3_cancel_data", 64'(q_enq_data),   64'(mk(1'b1, 6'd3, 16'd0)));
        tick();
        core_out_vld = 8'h00;

        // T4: full queue with a pending producer lets dispatch through
        q_full = 1'b1; core_out_vld = 8'h08; core_ready = 8'h02;
        core_out_msg[3*32 +: 32] = mk(1'b0, 6'd5, 16'd50);
        #1;
        chk("t4_deq",    64'(q_deq),        64'd1);
        chk("t4_evvld",  64'(core_ev_vld),  64'h02);
        chk("t4_ack",    64'(core_out_ack), 64'd0);
        chk("t4_enq",    64'(q_enq),        64'd0);
        chk("t4_fs_pre", 64'(full_stall),   64'd0);
        tick();
        q_full = 1'b0; core_out_vld = 8'h00; core_ready = 8'h00;
        #1;
        chk("t4_full_stall", 64'(full_stall), 64'd1);

        // GVT minimum across active cores and the queue head
        core_active = 8'h42;
        core_time[1*16 +: 16] = 16'd50;
        core_time[6*16 +: 16] = 16'd40;
        q_head = mk(1'b0, 6'd12, 16'd45);
        tick();
        chk("gvt_core_min", 64'(gvt), 64'd40);
        core_time[6*16 +: 16] = 16'd60;
        tick();
        chk("gvt_queue_min", 64'(gvt), 64'd45);
        core_active = 8'h00;

        // T5: gvt passes end_time
        q_head = mk(1'b0, 6'd12, 16'd101);
        tick();
        chk("t5_gvt",      64'(gvt),      64'd101);
        chk("t5_done_pre", 64'(done),     64'd0);
        tick();
        chk("t5_done",     64'(done),     64'd1);
        chk("t5_busy_fin", 64'(busy),     64'd1);
        chk("t5_quies",    64'(quiesced), 64'd0);
        tick();
        chk("t5_done_end", 64'(done),     64'd0);
        chk("t5_idle",     64'(busy),     64'd0);
        chk("t5_gvt_held", 64'(gvt),      64'd101);

        // T5b: quiescence
        q_empty = 1'b1; end_time = 16'hFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        chk("q_gvt_clr", 64'(gvt),        64'd0);
        chk("q_fs_clr",  64'(full_stall), 64'd0);
        chk("q_busy",    64'(busy),       64'd1);
        repeat (64) tick();
        chk("q_run_done0", 64'(done), 64'd0);
        tick();
        chk("q_run_done1", 64'(done), 64'd0);
        tick();
        chk("q_done",      64'(done),     64'd1);
        chk("q_quiesced",  64'(quiesced), 64'd1);
        tick();
        chk("q_idle",        64'(busy),     64'd0);
        chk("q_quies_stick", 64'(quiesced), 64'd1);

        // T6: pause blocks dispatch, then async reset mid-run
        q_empty = 1'b0; q_head = mk(1'b0, 6'd1, 16'd33); start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_quies_clr", 64'(quiesced), 64'd0);
        repeat (64) tick();
        pause = 1'b1; core_ready = 8'h08;
        #1;
        chk("t6_pause_deq",   64'(q_deq),       64'd0);
        chk("t6_pause_evvld", 64'(core_ev_vld), 64'd0);
        tick();
        chk("t6_gvt",        64'(gvt),   64'd33);
        chk("t6_pause_deq2", 64'(q_deq), 64'd0);
        pause = 1'b0;
        #1;
        chk("t6_resume_deq",   64'(q_deq),       64'd1);
        chk("t6_resume_evvld", 64'(core_ev_vld), 64'h08);
        tick();
        core_ready = 8'h00;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 64'(busy),  64'd0);
        chk("t6_rst_gvt",  64'(gvt),   64'd0);
        chk("t6_rst_done", 64'(done),  64'd0);
        chk("t6_rst_deq",  64'(q_deq), 64'd0);
        #10;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
